// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input, one-word holding register, and a
// start/data/parity/stop serialiser that chains held words with no idle gap.
module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 115_200,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ena,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  txd,
   output logic                  busy
);

   localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W       = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
   localparam int BIT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   generate
      if (PULSE_WIDTH < 2) begin : g_bad_pulse_width
         $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_tx: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
         $error("uart_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t                state;
   logic [CNT_W-1:0]      baud_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic                  stop_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shift_next;
   logic                  parity_bit;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_full;
   logic                  accept;
   logic                  baud_end;
   logic                  load_parity;
   logic                  last_stop;

   assign tx_ready    = ena & ~hold_full;
   assign busy        = (state != ST_IDLE) | hold_full;
   assign accept      = tx_valid & tx_ready;
   assign baud_end    = (baud_cnt == CNT_W'(PULSE_WIDTH - 1));
   assign shift_next  = shift_reg >> 1;
   assign last_stop   = (stop_cnt == 1'(STOP_BITS - 1));
   // Parity is fixed at load time so the shifting register cannot disturb it.
   assign load_parity = (PARITY == 2) ? ^hold_data : ~^hold_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         hold_data  <= '0;
         hold_full  <= 1'b0;
         txd        <= 1'b1;
      end else if (ena) begin
         // accept and load never coincide: accept needs the holder empty, load needs it full
         if (accept) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
         end

         if (state != ST_IDLE) begin
            baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               txd <= 1'b1;
               if (hold_full) begin
                  shift_reg  <= hold_data;
                  parity_bit <= load_parity;
                  hold_full  <= 1'b0;
                  txd        <= 1'b0;
                  state      <= ST_START;
               end
            end

            ST_START: begin
               if (baud_end) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                  txd     <= shift_reg[0];
               end
            end

            ST_DATA: begin
               if (baud_end) begin
                  if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                     if (PARITY != 0) begin
                        state <= ST_PARITY;
                        txd   <= parity_bit;
                     end else begin
                        state    <= ST_STOP;
                        stop_cnt <= 1'b0;
                        txd      <= 1'b1;
                     end
                  end else begin
                     shift_reg <= shift_next;
                     txd       <= shift_next[0];
                     bit_cnt   <= bit_cnt + 1'b1;
                  end
               end
            end

            ST_PARITY: begin
               if (baud_end) begin
                  state    <= ST_STOP;
                  stop_cnt <= 1'b0;
                  txd      <= 1'b1;
               end
            end

            ST_STOP: begin
               if (baud_end) begin
                  if (last_stop) begin
                     // chain straight into the next start bit when a word is waiting
                     if (hold_full) begin
                        shift_reg  <= hold_data;
                        parity_bit <= load_parity;
                        hold_full  <= 1'b0;
                        txd        <= 1'b0;
                        state      <= ST_START;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule
